// File: rtl/spi_reg_pkg.sv
// Shared register map, frame layout and FSM encoding for the SPI-to-PWM
// configuration path.
package spi_reg_pkg;

  // Register addresses carried in frame bits 14:8
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;
  localparam logic [6:0] MAX_ADDR       = 7'd4;

  // Frame field positions
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  // Register bank shape: addresses 0..1 are always live, 2..4 may be staged
  localparam int NUM_REGS     = 5;
  localparam int FIRST_STAGED = 2;
  localparam int NUM_STAGED   = NUM_REGS - FIRST_STAGED;

  // Frame handling FSM
  localparam int          STATE_W   = 1;
  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_DECODE = 1'b1;

  // True when a decoded frame must be dropped (read, or address out of map)
  function automatic logic frame_is_bad(input logic rw, input logic [6:0] addr);
    return (!rw) || (addr > MAX_ADDR);
  endfunction

endpackage

// File: rtl/pwm_cfg_scheduler.sv
// Register-update controller: takes SPI write frames, updates output-enable
// registers at once and holds PWM-affecting registers in a shadow bank until
// the next PWM period boundary (or a timeout) so a period never sees a
// half-applied configuration.
module pwm_cfg_scheduler
  import spi_reg_pkg::*;
#(
  parameter int SYNC_UPDATES   = 1,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  output logic        frame_ready,
  input  logic        pwm_period_start,
  output logic [7:0]  en_reg_out_7_0,
  output logic [7:0]  en_reg_out_15_8,
  output logic [7:0]  en_reg_pwm_7_0,
  output logic [7:0]  en_reg_pwm_15_8,
  output logic [7:0]  pwm_duty_cycle,
  output logic        update_pending,
  output logic        frame_error
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [15:0]           hold_q, hold_d;
  logic [7:0]            live_q   [NUM_REGS];
  logic [7:0]            live_d   [NUM_REGS];
  logic [7:0]            shadow_q [NUM_STAGED];
  logic [7:0]            shadow_d [NUM_STAGED];
  logic [NUM_STAGED-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic       hold_rw;
  logic [6:0] hold_addr;
  logic [7:0] hold_data;
  logic       timeout_hit;
  logic       commit;

  assign hold_rw   = hold_q[RW_BIT];
  assign hold_addr = hold_q[ADDR_MSB:ADDR_LSB];
  assign hold_data = hold_q[DATA_MSB:0];

  // A timeout of zero means "wait for a boundary forever"
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_VAL);
  assign commit      = (pending_q != '0) && (pwm_period_start || timeout_hit);

  // Frame FSM, commit of staged values and decode of the held frame
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    err_d     = 1'b0;
    live_d    = live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    // Commit works from the pre-edge shadows/mask; a decode at the same edge
    // is applied afterwards so its staged write survives into the new mask.
    if (commit) begin
      for (int i = 0; i < NUM_STAGED; i++) begin
        if (pending_q[i]) begin
          live_d[FIRST_STAGED + i] = shadow_q[i];
        end
      end
      pending_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          hold_d  = frame_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (frame_is_bad(hold_rw, hold_addr)) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < FIRST_STAGED; i++) begin
            if (hold_addr == 7'(i)) begin
              live_d[i] = hold_data;
            end
          end
          for (int j = 0; j < NUM_STAGED; j++) begin
            if (hold_addr == 7'(FIRST_STAGED + j)) begin
              if (SYNC_UPDATES == 0) begin
                live_d[FIRST_STAGED + j] = hold_data;
              end else begin
                shadow_d[j]  = hold_data;
                pending_d[j] = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending-age counter: runs only while something is staged, saturates
  always_comb begin
    cnt_d = cnt_q;
    if (commit || (pending_q == '0)) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset throws away any held frame and staged data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i] <= '0;
      end
      for (int j = 0; j < NUM_STAGED; j++) begin
        shadow_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i] <= live_d[i];
      end
      for (int j = 0; j < NUM_STAGED; j++) begin
        shadow_q[j] <= shadow_d[j];
      end
    end
  end

  assign frame_ready     = (state_q == ST_IDLE);
  assign frame_error     = err_q;
  assign update_pending  = |pending_q;
  assign en_reg_out_7_0  = live_q[0];
  assign en_reg_out_15_8 = live_q[1];
  assign en_reg_pwm_7_0  = live_q[2];
  assign en_reg_pwm_15_8 = live_q[3];
  assign pwm_duty_cycle  = live_q[4];

endmodule

// File: doc/pwm_cfg_scheduler.md
# pwm_cfg_scheduler

Register-update controller between the SPI peripheral frontend and the PWM/output-enable datapath. Accepts completed 16-bit SPI write frames and decodes address and data. Output-enable registers update immediately; PWM-affecting registers are staged and committed at the next PWM period boundary, which prevents mid-period glitches. A timeout forces the commit if no boundary arrives.

## Interface
Parameters:
- `SYNC_UPDATES`, default 1: 1 = PWM registers are staged until a boundary; 0 = all registers update immediately and the shadow path is bypassed.
- `TIMEOUT_CYCLES`, default 65535: cycles with staged data pending before a forced commit; 0 disables the timeout.
- `CNT_W`, default 16: timeout counter width; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_valid` in 1: frontend has a complete frame.
- `frame_data` in 16: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
- `frame_ready` out 1: block can accept a frame.
- `pwm_period_start` in 1: one-cycle pulse at a PWM period boundary.
- `en_reg_out_7_0` out 8: address 0x00, live.
- `en_reg_out_15_8` out 8: address 0x01, live.
- `en_reg_pwm_7_0` out 8: address 0x02, live (committed).
- `en_reg_pwm_15_8` out 8: address 0x03, live (committed).
- `pwm_duty_cycle` out 8: address 0x04, live (committed).
- `update_pending` out 1: at least one staged register awaits commit.
- `frame_error` out 1: one-cycle pulse when a frame is dropped.

## Operation
- Handshake:
  - A frame is accepted at the rising edge where `frame_valid & frame_ready`.
  - The frontend holds `frame_valid` and `frame_data` stable until accepted.
- Two-state FSM:
  - IDLE: `frame_ready`=1. On acceptance, capture `frame_data` into the hold register and go to DECODE.
  - DECODE: `frame_ready`=0. Process the held frame, then go to IDLE unconditionally.
  - Maximum throughput is one frame per 2 cycles.
- Decode rules:
  - bit 15 = 0 (read): drop and pulse `frame_error`; no register changes.
  - Address > 4 (MAX_ADDR): drop and pulse `frame_error`.
  - Address 0x00/0x01: write the live register directly.
  - Address 0x02–0x04 with `SYNC_UPDATES`=1: write the shadow register and set its bit in the 3-bit pending mask.
  - Address 0x02–0x04 with `SYNC_UPDATES`=0: write the live register directly; the pending mask stays 0.
- Commit:
  - Occurs at the edge where pending≠0 and either `pwm_period_start`=1, or the timeout counter equals `TIMEOUT_CYCLES` (with `TIMEOUT_CYCLES`≠0).
  - Copies each shadow register whose pending bit is set into its live register, then clears the whole mask.
  - Shadow registers without a pending bit leave their live value unchanged.
- Timeout counter:
  - Increments each cycle while pending≠0.
  - Clears to 0 on commit and whenever pending=0.
  - Saturates; never wraps.
- `update_pending` = |pending mask (registered).
- Repeated writes to the same staged address before a commit: last write wins, and only one commit occurs.

## Timing
- Reset: all five data outputs, shadows, pending mask, counter, `update_pending` and `frame_error` are 0. `frame_ready`=1 in the first cycle after reset release; FSM is in IDLE.
- Reset asserted mid-operation (in DECODE, or with pending≠0) discards the held frame and staged data; nothing commits.
- Latency for an immediate write: accept at edge E, live output updated at edge E+1.
- `frame_error` is high for exactly the cycle after E+1.
- Latency for a staged write: shadow and pending are set at E+1; commit occurs at the first qualifying edge strictly after E+1.
  - A `pwm_period_start` at edge E+1 itself does not commit that frame.
- Simultaneous DECODE shadow write and commit at the same edge:
  - The commit uses the pre-edge shadows and mask.
  - After the edge, the new write's shadow value and pending bit remain set; it is not lost.
- `pwm_period_start` with pending=0 has no effect.
- A timeout commit and `pwm_period_start` at the same edge produce one commit.

## Structure
- Shared package `spi_reg_pkg`:
  - Address localparams `ADDR_EN_OUT_LO`=0, `ADDR_EN_OUT_HI`=1, `ADDR_EN_PWM_LO`=2, `ADDR_EN_PWM_HI`=3, `ADDR_PWM_DUTY`=4.
  - `MAX_ADDR`=4.
  - Frame field positions: `RW_BIT`=15, `ADDR_MSB`=14, `ADDR_LSB`=8, `DATA_MSB`=7.
  - State encoding for IDLE/DECODE.
- No sub-module: the FSM, shadow bank and timeout counter stay in one module.

## Test plan
- After reset, no stimulus: all outputs 0, `frame_ready`=1, `update_pending`=0.
- Write 0x80FF (addr 0, data 0xFF): `en_reg_out_7_0`=0xFF one edge after acceptance; `update_pending` stays 0.
- Write 0x8480 (addr 4, data 0x80) followed 50 cycles later by a `pwm_period_start` pulse:
  - `update_pending`=1 and `pwm_duty_cycle`=0 until the pulse.
  - After the pulse edge, `pwm_duty_cycle`=0x80 and `update_pending`=0.
- Dropped frames:
  - Write 0x8512 (addr 5): `frame_error` pulses for 1 cycle; no output changes.
  - Read 0x0412: the same response.
- Write 0x8401 then 0x8402 before any boundary, then one `pwm_period_start`: `pwm_duty_cycle`=0x02 after a single commit. With `TIMEOUT_CYCLES`=10 and no boundary after a write to addr 3: the commit happens after the 10th pending cycle.
- Shadow write in DECODE at the same edge as `pwm_period_start`: the earlier staged value commits; the new value remains pending and commits at the next pulse. With reset asserted while pending=1: all outputs 0 and no commit after release.
